// File: rtl/cpu_pkg.sv
// cpu_pkg: PC source select codes, reset/exception vectors and PC-select FSM state type
package cpu_pkg;
  localparam int PCSRC_INC = 0;
  localparam int PCSRC_BR  = 1;
  localparam int PCSRC_JMP = 2;
  localparam int PCSRC_EPC = 3;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'h0000_0180;
  typedef enum logic {RUN, HOLD} pc_state_e;
endpackage

// File: rtl/pc_src_mux.sv
// pc_src_mux: N:1 selector (sel, data -> out) that returns fallback and valid=0 when sel >= N
module pc_src_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] data,
  input  logic [WIDTH-1:0]   fallback,
  output logic [WIDTH-1:0]   out,
  output logic               valid
);
  always_comb begin
    out   = fallback;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (32'(sel) == i) begin
        out   = data[i*WIDTH +: WIDTH];
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pc_select_unit.sv
// pc_select_unit: PC register + source select with stall-deferred redirect (pending) and sticky misalign_err; pc_target is the live selected source
module pc_select_unit
  import cpu_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               NUM_SRC    = 4,
  parameter int               SEL_W      = $clog2(NUM_SRC),
  parameter logic [WIDTH-1:0] RESET_VEC  = WIDTH'(RESET_VECTOR),
  parameter int               ALIGN_BITS = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     cond_true,
  input  logic                     stall,
  input  logic                     err_clear,
  output logic [WIDTH-1:0]         pc_out,
  output logic [WIDTH-1:0]         pc_target,
  output logic                     pending,
  output logic                     misalign_err
);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~({WIDTH{1'b1}} << ALIGN_BITS);
  pc_state_e        state;
  logic [WIDTH-1:0] hold_pc;
  logic             sel_ok;
  logic             req;
  logic             mis;
  logic             good;
  pc_src_mux #(.WIDTH(WIDTH), .N(NUM_SRC), .SEL_W(SEL_W)) u_mux (
    .sel      (sel),
    .data     (src_data),
    .fallback (pc_out),
    .out      (pc_target),
    .valid    (sel_ok)
  );
  assign req  = sel_ok & (pc_write | (pc_write_cond & cond_true));
  assign mis  = |(pc_target & ALIGN_MASK);
  assign good = req & ~mis;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      pc_out       <= RESET_VEC;
      hold_pc      <= '0;
      pending      <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= (req & mis) | (misalign_err & ~err_clear);
      if (state == RUN) begin
        if (good & ~stall) pc_out <= pc_target;
        else if (good) begin
          hold_pc <= pc_target;
          state   <= HOLD;
          pending <= 1'b1;
        end
      end else if (stall) begin
        if (good) hold_pc <= pc_target;
      end else begin
        pc_out  <= good ? pc_target : hold_pc;
        state   <= RUN;
        pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pc_select_unit.sv
// tb_pc_select_unit: directed vectors with hand-computed expectations for pc_select_unit
module tb_pc_select_unit;
  import cpu_pkg::*;
  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   sel;
  logic [127:0] src;
  logic         pc_write, pc_write_cond, cond_true, stall, err_clear;
  logic [31:0]  pc_out, pc_target;
  logic         pending, misalign_err;
  logic [1:0]   sel3;
  logic [95:0]  src3;
  logic         wr3;
  logic [31:0]  pc3, tgt3;
  logic         pend3, err3;
  int           n_checks = 0;
  int           n_fail = 0;
  always #5 clk = ~clk;
  pc_select_unit dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .src_data(src),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond_true(cond_true),
    .stall(stall), .err_clear(err_clear), .pc_out(pc_out), .pc_target(pc_target),
    .pending(pending), .misalign_err(misalign_err)
  );
  pc_select_unit #(.NUM_SRC(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .sel(sel3), .src_data(src3),
    .pc_write(wr3), .pc_write_cond(1'b0), .cond_true(1'b0),
    .stall(1'b0), .err_clear(1'b0), .pc_out(pc3), .pc_target(tgt3),
    .pending(pend3), .misalign_err(err3)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set_src(input int i, input logic [31:0] v);
    src[i*32 +: 32] = v;
  endtask
  initial begin
    reset_n = 1'b0; sel = '0; src = '0; pc_write = 0; pc_write_cond = 0;
    cond_true = 0; stall = 0; err_clear = 0; sel3 = '0; src3 = '0; wr3 = 0;
    set_src(PCSRC_INC, 32'h4); set_src(PCSRC_BR, 32'h100);
    set_src(PCSRC_JMP, 32'h40); set_src(PCSRC_EPC, 32'h200);
    #12 reset_n = 1'b1;
    check("rst_pc", pc_out, 32'h0);
    check("rst_pend", 32'(pending), 32'h0);
    check("rst_err", 32'(misalign_err), 32'h0);
    sel = 2'(PCSRC_JMP); pc_write = 1;
    #1 check("target_comb", pc_target, 32'h40);
    step; check("uncond_load", pc_out, 32'h40);
    pc_write = 0; sel = 2'(PCSRC_BR); pc_write_cond = 1; cond_true = 0;
    step; check("cond_false", pc_out, 32'h40);
    cond_true = 1;
    step; check("cond_true", pc_out, 32'h100);
    pc_write_cond = 0; cond_true = 0;
    stall = 1; sel = 2'(PCSRC_EPC); pc_write = 1;
    step; check("stall_pend", 32'(pending), 32'h1);
    check("stall_hold", pc_out, 32'h100);
    set_src(PCSRC_EPC, 32'h300);
    step; check("overwrite_hold", pc_out, 32'h100);
    pc_write = 0;
    step; check("hold_pend", 32'(pending), 32'h1);
    stall = 0;
    step; check("release_pc", pc_out, 32'h300);
    check("release_pend", 32'(pending), 32'h0);
    set_src(PCSRC_EPC, 32'h200); stall = 1; pc_write = 1;
    step; check("hold2_pend", 32'(pending), 32'h1);
    stall = 0; sel = 2'(PCSRC_JMP); set_src(PCSRC_JMP, 32'h400);
    step; check("release_new_pc", pc_out, 32'h400);
    check("release_new_pend", 32'(pending), 32'h0);
    pc_write = 0;
    step; check("no_stale_buf", pc_out, 32'h400);
    sel = 2'(PCSRC_BR); set_src(PCSRC_BR, 32'h102); pc_write = 1;
    step; check("mis_pc", pc_out, 32'h400);
    check("mis_err", 32'(misalign_err), 32'h1);
    pc_write = 0;
    step; check("err_sticky", 32'(misalign_err), 32'h1);
    err_clear = 1; pc_write = 1;
    step; check("set_wins", 32'(misalign_err), 32'h1);
    pc_write = 0;
    step; check("err_cleared", 32'(misalign_err), 32'h0);
    err_clear = 0;
    stall = 1; sel = 2'(PCSRC_JMP); set_src(PCSRC_JMP, 32'h500); pc_write = 1;
    step; check("hold3_pend", 32'(pending), 32'h1);
    stall = 0; sel = 2'(PCSRC_BR);
    step; check("mis_release_pc", pc_out, 32'h500);
    check("mis_release_err", 32'(misalign_err), 32'h1);
    check("mis_release_pend", 32'(pending), 32'h0);
    pc_write = 0; err_clear = 1;
    step; err_clear = 0;
    stall = 1; pc_write = 1;
    step; check("mis_stall_nobuf", 32'(pending), 32'h0);
    check("mis_stall_err", 32'(misalign_err), 32'h1);
    check("mis_stall_pc", pc_out, 32'h500);
    pc_write = 0; stall = 0;
    src3[2*32 +: 32] = 32'h80; sel3 = 2'd3; wr3 = 1;
    #1 check("oor_target", tgt3, 32'h0);
    step; check("oor_noload", pc3, 32'h0);
    sel3 = 2'd2;
    step; check("n3_load", pc3, 32'h80);
    sel3 = 2'd3;
    #1 check("oor_target_pc", tgt3, 32'h80);
    step; check("oor_hold", pc3, 32'h80);
    check("oor_noerr", 32'(err3), 32'h0);
    wr3 = 0;
    stall = 1; sel = 2'(PCSRC_JMP); set_src(PCSRC_JMP, 32'h600); pc_write = 1;
    step; check("hold4_pend", 32'(pending), 32'h1);
    pc_write = 0;
    #2 reset_n = 1'b0;
    #1 check("async_rst_pc", pc_out, 32'h0);
    check("async_rst_pend", 32'(pending), 32'h0);
    check("async_rst_err", 32'(misalign_err), 32'h0);
    #2 reset_n = 1'b1; stall = 0;
    step; check("rst_drops_buf", pc_out, 32'h0);
    check("rst_drops_pend", 32'(pending), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
